// File: rtl/sr_mdu_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Op encodings (funct3), FSM states and latched control bundle.
package sr_mdu_pkg;

  localparam int XLEN = 32;
  localparam int CW = $clog2(XLEN);
  localparam logic [6:0] RVF7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } mdu_state_t;

  typedef struct packed {
    mdu_op_t op;
    logic    neg_a;
    logic    neg_b;
    logic    div0;
    logic    ovf;
  } mdu_ctl_t;

endpackage

// File: rtl/sr_mdu_if.sv
// Request/response bundle between sr_control and sr_mdu.
// master: control side (clear, vld_in, op, srcA, srcB); slave: MDU.
interface sr_mdu_if;
  import sr_mdu_pkg::*;

  logic            clear;
  logic            vld_in;
  logic [2:0]      op;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            busy;
  logic            vld_out;
  logic [XLEN-1:0] result;

  modport master (
    output clear, vld_in, op, srcA, srcB,
    input  busy, vld_out, result
  );

  modport slave (
    input  clear, vld_in, op, srcA, srcB,
    output busy, vld_out, result
  );

endinterface

// File: rtl/sr_mdu_signfix.sv
// Conditional two's-complement negation, used for operand abs and
// result sign fix. Ports: a (value), neg (negate), y (result).
module sr_mdu_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? -a : a;

endmodule

// File: rtl/sr_mdu.sv
// Iterative RV32M MUL/DIV unit, one bit per cycle, fixed latency.
// Ports: clk, reset_n (async low), mdu (slave: handshake + result).
module sr_mdu
  import sr_mdu_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  sr_mdu_if.slave mdu
);

  mdu_state_t      state, state_nxt;
  mdu_ctl_t        ctl;
  mdu_op_t         op_in;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc, q, opb, res;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            sgn_a, sgn_b;
  logic            neg_a, neg_b;
  logic            div0, ovf;
  logic            start, last;

  assign op_in = mdu_op_t'(mdu.op);

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    unique case (op_in)
      MDU_MULH, MDU_DIV, MDU_REM: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      MDU_MULHSU: sgn_a = 1'b1;
      default: ;
    endcase
  end

  assign neg_a = sgn_a & mdu.srcA[XLEN-1];
  assign neg_b = sgn_b & mdu.srcB[XLEN-1];
  assign div0  = op_in[2] & (mdu.srcB == '0);
  assign ovf   = op_in[2] & ~op_in[0]
               & (mdu.srcA == {1'b1, {(XLEN-1){1'b0}}})
               & (mdu.srcB == '1);

  sr_mdu_signfix #(.W(XLEN)) u_abs_a (
    .a(mdu.srcA), .neg(neg_a), .y(abs_a)
  );
  sr_mdu_signfix #(.W(XLEN)) u_abs_b (
    .a(mdu.srcB), .neg(neg_b), .y(abs_b)
  );

  assign start = (state == S_IDLE)
               & mdu.vld_in & ~mdu.clear;
  assign last  = (cnt == CW'(XLEN-1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (mdu.clear) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (mdu.vld_in) state_nxt = S_CALC;
        S_CALC: if (last) state_nxt = S_DONE;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mdu.busy    = (state != S_IDLE);
    mdu.vld_out = (state == S_DONE);
  end

  // Shared adder: mul adds the multiplicand into hi, div subtracts
  // the divisor from the shifted remainder. The extra top bit is the
  // carry, which for subtraction means "no borrow" (rem >= divisor).
  logic            mul;
  logic [XLEN:0]   add_a, add_b;
  logic [XLEN+1:0] sum;
  logic            geq;
  logic [XLEN-1:0] acc_nxt, q_nxt;

  assign mul = ~ctl.op[2];

  always_comb begin
    if (mul) begin
      add_a = {1'b0, acc};
      add_b = {1'b0, q[0] ? opb : '0};
    end else begin
      add_a = {acc, q[XLEN-1]};
      add_b = ~{1'b0, opb};
    end
    sum = {1'b0, add_a} + {1'b0, add_b}
        + {{(XLEN+1){1'b0}}, ~mul};
    geq = sum[XLEN+1];
    if (mul) begin
      acc_nxt = sum[XLEN:1];
      q_nxt   = {sum[0], q[XLEN-1:1]};
    end else begin
      acc_nxt = geq ? sum[XLEN-1:0] : add_a[XLEN-1:0];
      q_nxt   = {q[XLEN-2:0], geq};
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, res_fin;
  logic              is_lo, is_hi, is_quo, is_rem;

  sr_mdu_signfix #(.W(2*XLEN)) u_fix_p (
    .a({acc_nxt, q_nxt}),
    .neg(ctl.neg_a ^ ctl.neg_b),
    .y(prod)
  );
  sr_mdu_signfix #(.W(XLEN)) u_fix_q (
    .a(q_nxt), .neg(ctl.neg_a ^ ctl.neg_b), .y(quo)
  );
  sr_mdu_signfix #(.W(XLEN)) u_fix_r (
    .a(acc_nxt), .neg(ctl.neg_a), .y(rem)
  );

  assign is_lo  = mul & (ctl.op[1:0] == 2'b00);
  assign is_hi  = mul & (ctl.op[1:0] != 2'b00);
  assign is_quo = ~mul & ~ctl.op[1];
  assign is_rem = ~mul & ctl.op[1];

  // Divide-by-zero remainder already equals srcA after the
  // restoring loop plus the dividend-sign fix, so only the
  // quotient needs forcing there.
  always_comb begin
    res_fin = '0;
    unique case (1'b1)
      is_lo:  res_fin = prod[XLEN-1:0];
      is_hi:  res_fin = prod[2*XLEN-1:XLEN];
      is_quo: begin
        if (ctl.div0)     res_fin = '1;
        else if (ctl.ovf) res_fin = {1'b1, {(XLEN-1){1'b0}}};
        else              res_fin = quo;
      end
      is_rem: res_fin = ctl.ovf ? '0 : rem;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctl <= '0;
      cnt <= '0;
      acc <= '0;
      q   <= '0;
      opb <= '0;
      res <= '0;
    end else if (start) begin
      ctl <= '{op: op_in, neg_a: neg_a, neg_b: neg_b,
               div0: div0, ovf: ovf};
      cnt <= '0;
      acc <= '0;
      q   <= op_in[2] ? abs_a : abs_b;
      opb <= op_in[2] ? abs_b : abs_a;
    end else if (state == S_CALC && !mdu.clear) begin
      acc <= acc_nxt;
      q   <= q_nxt;
      cnt <= cnt + CW'(1);
      if (last) res <= res_fin;
    end
  end

  assign mdu.result = res;

endmodule
